// File: rtl/boost_pwm_modulator_pkg.sv
// Shared definitions for the boost PWM modulator: FSM state encoding and the
// width used for the signed duty arithmetic.
package boost_pwm_modulator_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Two extra bits over the wider operand keep offset addition and clamping overflow-free.
   function automatic int calc_width(input int in_w, input int cnt_w);
      return ((in_w > cnt_w) ? in_w : cnt_w) + 2;
   endfunction

endpackage

// File: rtl/boost_pwm_modulator_duty_scale.sv
// Combinational duty scaling: arithmetic shift of the controller output, add the
// operating-point offset, saturate to the duty limits and flag saturation.
module pwm_duty_scale
   import boost_pwm_modulator_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int CNT_WIDTH   = 10,
   parameter int DUTY_OFFSET = 500,
   parameter int IN_SHIFT    = 6,
   parameter int DUTY_MIN    = 0,
   parameter int DUTY_MAX    = 900
) (
   input  logic signed [WIDTH-1:0]     in_data_i,
   output logic        [CNT_WIDTH-1:0] sat_o,
   output logic                        clamp_o
);

   localparam int CALC_W = calc_width(WIDTH, CNT_WIDTH);
   localparam logic signed [CALC_W-1:0] OFFSET_S = CALC_W'(DUTY_OFFSET);
   localparam logic signed [CALC_W-1:0] MIN_S    = CALC_W'(DUTY_MIN);
   localparam logic signed [CALC_W-1:0] MAX_S    = CALC_W'(DUTY_MAX);

   logic signed [CALC_W-1:0] in_ext;
   logic signed [CALC_W-1:0] raw;
   logic signed [CALC_W-1:0] sat;

   always_comb begin
      in_ext = {{(CALC_W-WIDTH){in_data_i[WIDTH-1]}}, in_data_i};
      raw    = (in_ext >>> IN_SHIFT) + OFFSET_S;
      if (raw < MIN_S) begin
         sat = MIN_S;
      end else if (raw > MAX_S) begin
         sat = MAX_S;
      end else begin
         sat = raw;
      end
   end

   assign sat_o   = sat[CNT_WIDTH-1:0];
   assign clamp_o = (raw != sat);

endmodule

// File: rtl/boost_pwm_modulator.sv
// Boost converter PWM stage: per-period shadowed duty, complementary gates with
// dead-time, period-start strobe and ADC sample trigger.
module boost_pwm_modulator
   import boost_pwm_modulator_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int CNT_WIDTH    = 10,
   parameter int PERIOD       = 1000,
   parameter int DUTY_OFFSET  = 500,
   parameter int IN_SHIFT     = 6,
   parameter int DUTY_MIN     = 0,
   parameter int DUTY_MAX     = 900,
   parameter int DEADTIME     = 4,
   parameter int SAMPLE_POINT = 250
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic signed [WIDTH-1:0]     inData,
   output logic                        pwmHigh,
   output logic                        pwmLow,
   output logic                        periodStart,
   output logic                        sampleTrig,
   output logic        [CNT_WIDTH-1:0] duty,
   output logic                        clamped
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PERIOD - 1);
   localparam logic [CNT_WIDTH-1:0] DT_CNT   = CNT_WIDTH'(DEADTIME);
   localparam logic [CNT_WIDTH:0]   DT_EXT   = (CNT_WIDTH+1)'(DEADTIME);
   localparam logic [CNT_WIDTH-1:0] SP_CNT   = CNT_WIDTH'(SAMPLE_POINT);
   localparam logic [CNT_WIDTH-1:0] DMIN_CNT = CNT_WIDTH'(DUTY_MIN);

   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]   duty_q, duty_d;
   logic                   clamped_q, clamped_d;
   logic                   high_q, high_d;
   logic                   low_q, low_d;
   logic                   start_q, start_d;
   logic                   trig_q, trig_d;
   logic [CNT_WIDTH-1:0]   sat;
   logic                   sat_clamp;

   pwm_duty_scale #(
      .WIDTH       (WIDTH),
      .CNT_WIDTH   (CNT_WIDTH),
      .DUTY_OFFSET (DUTY_OFFSET),
      .IN_SHIFT    (IN_SHIFT),
      .DUTY_MIN    (DUTY_MIN),
      .DUTY_MAX    (DUTY_MAX)
   ) u_scale (
      .in_data_i (inData),
      .sat_o     (sat),
      .clamp_o   (sat_clamp)
   );

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q;
      duty_d    = duty_q;
      clamped_d = clamped_q;
      high_d    = 1'b0;
      low_d     = 1'b0;
      start_d   = 1'b0;
      trig_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               duty_d    = sat;
               clamped_d = sat_clamp;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               high_d  = (cnt_q >= DT_CNT) && (cnt_q < duty_q);
               low_d   = ({1'b0, cnt_q} >= ({1'b0, duty_q} + DT_EXT));
               start_d = (cnt_q == '0);
               trig_d  = (cnt_q == SP_CNT);
               // Shadow reload on the last count so the new duty applies from cnt=0.
               if (cnt_q == CNT_LAST) begin
                  cnt_d     = '0;
                  duty_d    = sat;
                  clamped_d = sat_clamp;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         duty_q    <= DMIN_CNT;
         clamped_q <= 1'b0;
         high_q    <= 1'b0;
         low_q     <= 1'b0;
         start_q   <= 1'b0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         duty_q    <= duty_d;
         clamped_q <= clamped_d;
         high_q    <= high_d;
         low_q     <= low_d;
         start_q   <= start_d;
         trig_q    <= trig_d;
      end
   end

   assign pwmHigh     = high_q;
   assign pwmLow      = low_q;
   assign periodStart = start_q;
   assign sampleTrig  = trig_q;
   assign duty        = duty_q;
   assign clamped     = clamped_q;

endmodule
